// File: rtl/irq_pend_pkg.sv
// +----------------------------------------------------------------------+
// | irq_pend_pkg : shared types and constants for the IRQ pend collector |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package irq_pend_pkg;

  localparam int c_DEF_WIDTH = 8;
  localparam int IDX_W       = $clog2(c_DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/irq_sync_edge.sv
// +----------------------------------------------------------------------+
// | irq_sync_edge : multi-flop synchronizer with rising-edge detect      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module irq_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_chain;
  logic [WIDTH-1:0]                  r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
      r_prev  <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
      r_prev  <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];
  assign o_rise = r_chain[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/irq_pend_collector.sv
// +----------------------------------------------------------------------+
// | irq_pend_collector : pending register + frozen snapshot for pen      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module irq_pend_collector
  import irq_pend_pkg::*;
#(
  parameter int WIDTH       = c_DEF_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req_in,
  input  logic [WIDTH-1:0]         trig_edge,
  input  logic [WIDTH-1:0]         mask,
  input  logic [HOLDOFF_W-1:0]     holdoff,
  output logic [WIDTH-1:0]         pend_vec,
  output logic                     irq_valid,
  input  logic                     ack,
  input  logic [$clog2(WIDTH)-1:0] ack_id,
  output logic                     ack_err,
  output logic [WIDTH-1:0]         lost,
  input  logic                     lost_clr
);

  logic [WIDTH-1:0]     w_sync;
  logic [WIDTH-1:0]     w_rise;
  logic [WIDTH-1:0]     w_ack_onehot;
  logic [WIDTH-1:0]     w_clr;
  logic [WIDTH-1:0]     w_pending_nxt;
  logic [WIDTH-1:0]     w_lost_nxt;
  logic                 w_ack_take;
  logic                 w_ack_hit;

  state_t               r_state;
  logic [HOLDOFF_W-1:0] r_cnt;
  logic [WIDTH-1:0]     r_pending;
  logic [WIDTH-1:0]     r_pend_vec;
  logic                 r_irq_valid;
  logic                 r_ack_err;
  logic [WIDTH-1:0]     r_lost;

  irq_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (req_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  // Out-of-range ack_id shifts the one-hot to zero, so it can never hit.
  assign w_ack_take   = ack && (r_state == VALID);
  assign w_ack_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << ack_id;
  assign w_ack_hit    = w_ack_take && (|(w_ack_onehot & r_pend_vec));
  assign w_clr        = w_ack_hit ? (w_ack_onehot & trig_edge) : '0;

  assign w_pending_nxt = (trig_edge & (w_rise | (r_pending & ~w_clr)))
                       | (~trig_edge & w_sync);
  assign w_lost_nxt    = (r_lost & ~{WIDTH{lost_clr}})
                       | (trig_edge & w_rise & r_pending & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_lost    <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_lost    <= w_lost_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pend_vec  <= '0;
      r_irq_valid <= 1'b0;
      r_ack_err   <= 1'b0;
    end else begin
      r_ack_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|(r_pending & mask)) begin
            r_pend_vec  <= r_pending & mask;
            r_irq_valid <= 1'b1;
            r_state     <= VALID;
          end
        end
        VALID: begin
          if (ack) begin
            r_pend_vec  <= '0;
            r_irq_valid <= 1'b0;
            r_ack_err   <= ~w_ack_hit;
            if (holdoff == '0) begin
              r_state <= IDLE;
            end else begin
              r_cnt   <= holdoff - HOLDOFF_W'(1);
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - HOLDOFF_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pend_vec  = r_pend_vec;
  assign irq_valid = r_irq_valid;
  assign ack_err   = r_ack_err;
  assign lost      = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_irq_pend_collector.sv
// +----------------------------------------------------------------------+
// | tb_irq_pend_collector : directed self-checking bench                 |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_irq_pend_collector;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] trig_edge;
  logic [7:0] mask;
  logic [3:0] holdoff;
  logic [7:0] pend_vec;
  logic       irq_valid;
  logic       ack;
  logic [2:0] ack_id;
  logic       ack_err;
  logic [7:0] lost;
  logic       lost_clr;

  int total = 0;
  int bad   = 0;

  irq_pend_collector #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .HOLDOFF_W   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .trig_edge (trig_edge),
    .mask      (mask),
    .holdoff   (holdoff),
    .pend_vec  (pend_vec),
    .irq_valid (irq_valid),
    .ack       (ack),
    .ack_id    (ack_id),
    .ack_err   (ack_err),
    .lost      (lost),
    .lost_clr  (lost_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_ack(input logic [2:0] id);
    ack    = 1'b1;
    ack_id = id;
    cyc(1);
    ack    = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] bits);
    req_in = bits;
    cyc(1);
    req_in = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; req_in = 8'h00; trig_edge = 8'hFE; mask = 8'hFF;
    holdoff = 4'd0; ack = 1'b0; ack_id = 3'd0; lost_clr = 1'b0;
    cyc(2);
    chk("rst_vec",   32'(pend_vec),  32'h00);
    chk("rst_valid", 32'(irq_valid), 32'h0);
    chk("rst_err",   32'(ack_err),   32'h0);
    chk("rst_lost",  32'(lost),      32'h00);
    rst_n = 1'b1;
    cyc(1);

    // single edge request on bit 3
    pulse(8'h08);
    cyc(2);
    chk("t1_pend",   32'(dut.r_pending), 32'h08);
    chk("t1_early",  32'(irq_valid),     32'h0);
    cyc(1);
    chk("t1_valid",  32'(irq_valid),     32'h1);
    chk("t1_vec",    32'(pend_vec),      32'h08);
    do_ack(3'd3);
    chk("t1_ackv",   32'(irq_valid),     32'h0);
    chk("t1_ackp",   32'(dut.r_pending), 32'h00);
    chk("t1_err",    32'(ack_err),       32'h0);
    cyc(1);
    chk("t1_idle",   32'(irq_valid),     32'h0);

    // bits 1 and 6 together
    pulse(8'h42);
    cyc(3);
    chk("t2_vec",    32'(pend_vec),      32'h42);
    chk("t2_valid",  32'(irq_valid),     32'h1);
    do_ack(3'd6);
    chk("t2_pend",   32'(dut.r_pending), 32'h02);
    chk("t2_ackv",   32'(irq_valid),     32'h0);
    cyc(1);
    chk("t2_rev",    32'(pend_vec),      32'h02);
    chk("t2_rvalid", 32'(irq_valid),     32'h1);
    do_ack(3'd1);
    chk("t2_clr",    32'(dut.r_pending), 32'h00);

    // level bit 0
    req_in = 8'h01;
    cyc(4);
    chk("t3_valid",  32'(irq_valid),     32'h1);
    chk("t3_vec",    32'(pend_vec),      32'h01);
    do_ack(3'd0);
    chk("t3_ackv",   32'(irq_valid),     32'h0);
    chk("t3_lvl",    32'(dut.r_pending), 32'h01);
    cyc(1);
    chk("t3_again",  32'(irq_valid),     32'h1);
    req_in = 8'h00;
    cyc(3);
    chk("t3_drop",   32'(dut.r_pending), 32'h00);
    chk("t3_frozen", 32'(pend_vec),      32'h01);
    do_ack(3'd0);
    chk("t3_ack2",   32'(irq_valid),     32'h0);
    chk("t3_err",    32'(ack_err),       32'h0);
    cyc(2);
    chk("t3_stay",   32'(irq_valid),     32'h0);

    // hold-off of 3 with bit 2 still pending
    pulse(8'h84);
    cyc(3);
    chk("t4_vec",    32'(pend_vec),      32'h84);
    holdoff = 4'd3;
    do_ack(3'd7);
    holdoff = 4'd0;
    chk("t4_ackv",   32'(irq_valid),     32'h0);
    chk("t4_pend",   32'(dut.r_pending), 32'h04);
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      chk($sformatf("t4_hold%0d", i), 32'(irq_valid), 32'h0);
    end
    cyc(1);
    chk("t4_valid",  32'(irq_valid),     32'h1);
    chk("t4_rev",    32'(pend_vec),      32'h04);
    do_ack(3'd2);

    // loss detection, clear, and rise coincident with ack
    mask = 8'h00;
    pulse(8'h20);
    cyc(3);
    chk("t5_pend",   32'(dut.r_pending), 32'h20);
    chk("t5_masked", 32'(irq_valid),     32'h0);
    pulse(8'h20);
    cyc(2);
    chk("t5_lost",   32'(lost),          32'h20);
    lost_clr = 1'b1;
    cyc(1);
    lost_clr = 1'b0;
    chk("t5_lclr",   32'(lost),          32'h00);
    mask = 8'h20;
    cyc(1);
    chk("t5_vec",    32'(pend_vec),      32'h20);
    pulse(8'h20);
    cyc(1);
    do_ack(3'd5);
    chk("t5_setwin", 32'(dut.r_pending), 32'h20);
    chk("t5_noloss", 32'(lost),          32'h00);
    chk("t5_err",    32'(ack_err),       32'h0);
    cyc(1);
    chk("t5_rev",    32'(irq_valid),     32'h1);
    do_ack(3'd5);
    chk("t5_clr",    32'(dut.r_pending), 32'h00);

    // masking, ack error, async reset mid-VALID
    mask = 8'h00;
    pulse(8'h10);
    cyc(4);
    chk("t6_masked", 32'(irq_valid),     32'h0);
    chk("t6_pend",   32'(dut.r_pending), 32'h10);
    mask = 8'h10;
    cyc(1);
    chk("t6_valid",  32'(irq_valid),     32'h1);
    chk("t6_vec",    32'(pend_vec),      32'h10);
    do_ack(3'd2);
    chk("t6_err",    32'(ack_err),       32'h1);
    chk("t6_keep",   32'(dut.r_pending), 32'h10);
    cyc(1);
    chk("t6_errend", 32'(ack_err),       32'h0);
    chk("t6_rev",    32'(irq_valid),     32'h1);
    pulse(8'h10);
    cyc(2);
    chk("t6_lost",   32'(lost),          32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rvec",   32'(pend_vec),      32'h00);
    chk("t6_rvalid", 32'(irq_valid),     32'h0);
    chk("t6_rlost",  32'(lost),          32'h00);
    chk("t6_rpend",  32'(dut.r_pending), 32'h00);
    cyc(1);
    rst_n = 1'b1;

    // ack outside VALID is ignored
    do_ack(3'd0);
    chk("t7_noerr",  32'(ack_err),       32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
